lenet_layer2_input_buffer: RTL and testbench

//  Frame buffer between the layer-1 pooled outputs and the layer-2 channel array (lenet_channel_layer2 x16).

---
 rtl/lenet_layer2_input_buffer.sv | 140 ++++++++++++++
 tb/tb_lenet_layer2_input_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_layer2_input_buffer.sv
// Purpose: captures six 14x14 int8 maps written independently, then replays them as one lock-step broadcast stream.
// Latency: last write -> start_out 2 cycles (dst_ready high); start_out -> first out_valid START_GAP+2; reads 1 cycle.
// Backpressure: none on output; dst_ready only gates the start; writes outside FILL or past a full map are dropped (sticky overflow_err).
module lenet_layer2_input_buffer #(
    parameter int N_CH      = 6,
    parameter int MAPSIZE   = 14,
    parameter int PIX_W     = 8,
    parameter int START_GAP = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH-1:0]             in_valid,
    input  logic [N_CH-1:0][PIX_W-1:0]  in_pixel,
    input  logic                        dst_ready,
    output logic                        start_out,
    output logic [N_CH-1:0]             out_valid,
    output logic [N_CH-1:0][PIX_W-1:0]  out_pixel,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overflow_err
);

    localparam int FRAME = MAPSIZE * MAPSIZE;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int GW    = (START_GAP < 1) ? 1 : $clog2(START_GAP + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(START_GAP);

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT_DST,
        S_START,
        S_GAP,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     wr_cnt [N_CH];
    logic [CW-1:0]     rd_addr;
    logic [GW-1:0]     gap_cnt;
    logic              all_full;
    logic [PIX_W-1:0]  mem [N_CH][FRAME];

    // Next-state decode; a map counts as full in the same cycle its last write lands.
    always_comb begin
        next_state = state;
        all_full   = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (!((wr_cnt[i] == CNT_FULL) || (in_valid[i] && (wr_cnt[i] == CNT_LAST)))) begin
                all_full = 1'b0;
            end
        end
        case (state)
            S_FILL:     if (all_full)  next_state = S_WAIT_DST;
            S_WAIT_DST: if (dst_ready) next_state = S_START;
            S_START:    next_state = S_GAP;
            S_GAP:      if (gap_cnt <= GW'(1)) next_state = S_STREAM;
            S_STREAM:   if (rd_addr == CNT_LAST) next_state = S_DRAIN;
            S_DRAIN:    next_state = S_FILL;
            default:    next_state = S_FILL;
        endcase
    end

    // State register, write counters, read address, gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_FILL;
            rd_addr      <= '0;
            gap_cnt      <= '0;
            out_valid    <= '0;
            out_pixel    <= '0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                wr_cnt[i] <= '0;
            end
        end else begin
            state      <= next_state;
            out_valid  <= '0;
            frame_done <= 1'b0;

            if (state == S_FILL) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (in_valid[i]) begin
                        if (wr_cnt[i] != CNT_FULL) begin
                            wr_cnt[i] <= wr_cnt[i] + CW'(1);
                        end else begin
                            overflow_err <= 1'b1;
                        end
                    end
                end
            end else if (|in_valid) begin
                overflow_err <= 1'b1;
            end

            case (state)
                S_START: gap_cnt <= GAP_LOAD;
                S_GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    rd_addr <= '0;
                end
                S_STREAM: begin
                    out_valid  <= '1;
                    frame_done <= (rd_addr == CNT_LAST);
                    rd_addr    <= rd_addr + CW'(1);
                    for (int i = 0; i < N_CH; i++) begin
                        out_pixel[i] <= mem[i][rd_addr];
                    end
                end
                S_DRAIN: begin
                    rd_addr <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        wr_cnt[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-bank write port; contents survive reset, only counters restart.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if ((state == S_FILL) && in_valid[i] && (wr_cnt[i] != CNT_FULL)) begin
                mem[i][wr_cnt[i]] <= in_pixel[i];
            end
        end
    end

    // Start pulse and busy decode straight from state.
    always_comb begin
        start_out = (state == S_START);
        busy      = (state != S_FILL);
    end

endmodule

// File: tb/tb_lenet_layer2_input_buffer.sv
// Bench for the layer-2 input buffer: randomized fills checked by a replay scoreboard.
// Driver pushes each frame's expected 196 broadcast vectors; a negedge monitor pops and compares.
// All waits are cycle-bounded; the watchdog ends the run if anything stalls.
module tb_lenet_layer2_input_buffer;

    localparam int NCH   = 6;
    localparam int FRAME = 196;
    localparam int START_TO_VALID = 4;

    typedef struct packed {
        logic [47:0] dat;
        logic        last;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [5:0]       in_valid;
    logic [5:0][7:0]  in_pixel;
    logic             dst_ready;
    logic             start_out;
    logic [5:0]       out_valid;
    logic [5:0][7:0]  out_pixel;
    logic             frame_done;
    logic             busy;
    logic             overflow_err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   filling = 0;
    int   run_len = 0;
    int   fd_cnt = 0;
    int   start_cnt = 0;
    int   exp_fd = 0;
    int   exp_start = 0;

    lenet_layer2_input_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .dst_ready    (dst_ready),
        .start_out    (start_out),
        .out_valid    (out_valid),
        .out_pixel    (out_pixel),
        .frame_done   (frame_done),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every replay beat and tracks pulses/latency.
    initial begin
        bit prev_v;
        bit await_first;
        int cyc;
        int start_cyc;
        exp_t e;
        prev_v = 0;
        await_first = 0;
        cyc = 0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (filling) chk("start_during_fill", {63'd0, start_out}, 64'd0);
            if (start_out) begin
                start_cnt++;
                start_cyc = cyc;
                await_first = 1;
            end
            if (out_valid != 6'd0) begin
                if (!prev_v) begin
                    run_len = 0;
                    if (await_first) chk("start_to_valid", 64'(cyc - start_cyc), 64'(START_TO_VALID));
                    await_first = 0;
                end
                run_len++;
                chk("out_valid_all", {58'd0, out_valid}, 64'h3F);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", {16'd0, out_pixel}, {16'd0, e.dat});
                    chk("frame_done_pos", {63'd0, frame_done}, {63'd0, e.last});
                    if (frame_done) chk("run_len", 64'(run_len), 64'(FRAME));
                end
            end else if (frame_done) begin
                chk("frame_done_no_valid", 64'd1, 64'd0);
            end
            if (frame_done) fd_cnt++;
            prev_v = (out_valid != 6'd0);
        end
    end

    // Drives one map fill and queues its expected replay.
    // mode 0: ch*16+idx[3:0], 1: negated pattern, 2: random.
    task automatic do_fill(input int mode, input bit stagger, input bit extra2, input bit rand_rate);
        logic [7:0]  d [NCH][FRAME];
        logic [47:0] v;
        exp_t        e;
        int          ptr [NCH];
        int          st [NCH];
        int          cyc;
        int          x;
        bit          ex_done;
        bit          any_left;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < FRAME; k++) begin
                x = c * 16 + (k % 16);
                if (mode == 1) x = -x;
                if (mode == 2) x = int'($urandom_range(0, 255));
                d[c][k] = 8'(x);
            end
            ptr[c] = 0;
            st[c]  = stagger ? (5 - c) * 7 : 0;
        end
        for (int k = 0; k < FRAME; k++) begin
            for (int c = 0; c < NCH; c++) v[c*8 +: 8] = d[c][k];
            e.dat  = v;
            e.last = (k == FRAME - 1);
            sb.push_back(e);
        end
        ex_done = 0;
        cyc = 0;
        filling = 1;
        any_left = 1;
        while (any_left && cyc < 5000) begin
            in_valid = '0;
            for (int c = 0; c < NCH; c++) begin
                in_pixel[c] = 8'($urandom_range(0, 255));
                if (cyc >= st[c] && ptr[c] < FRAME && (!rand_rate || $urandom_range(0, 2) != 0)) begin
                    in_valid[c] = 1'b1;
                    in_pixel[c] = d[c][ptr[c]];
                    ptr[c]++;
                end
            end
            if (extra2 && !ex_done && ptr[2] == FRAME && !in_valid[2] && ptr[0] < FRAME) begin
                in_valid[2] = 1'b1;
                in_pixel[2] = ~d[2][FRAME-1];
                ex_done = 1;
            end
            tick();
            cyc++;
            any_left = 0;
            for (int c = 0; c < NCH; c++) if (ptr[c] < FRAME) any_left = 1;
        end
        in_valid = '0;
        filling = 0;
        if (any_left) chk("fill_timeout", 64'd1, 64'd0);
        if (extra2) chk("extra_write_issued", {63'd0, ex_done}, 64'd1);
        exp_start++;
    endtask

    // Called right after do_fill when dst_ready was already high.
    task automatic check_fill_latency();
        chk("start_lat_t1", {63'd0, start_out}, 64'd0);
        tick();
        chk("start_lat_t2", {63'd0, start_out}, 64'd1);
    endtask

    task automatic wait_frame();
        int target;
        int n;
        target = exp_fd + 1;
        n = 0;
        while (fd_cnt < target && n < 1000) begin
            tick();
            n++;
        end
        chk("frame_done_timeout", 64'(fd_cnt >= target), 64'd1);
        exp_fd++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0;
        in_valid = '0;
        in_pixel = '0;
        dst_ready = 1;
        repeat (3) tick();
        chk("rst_out_valid", {58'd0, out_valid}, 64'd0);
        chk("rst_out_pixel", {16'd0, out_pixel}, 64'd0);
        chk("rst_start", {63'd0, start_out}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        rst_n = 1;
        tick();

        // T1: simultaneous fill, destination ready.
        do_fill(0, 0, 0, 0);
        check_fill_latency();
        wait_frame();
        tick();

        // T2: staggered completion, ch5 first, ch0 last.
        do_fill(0, 1, 0, 0);
        check_fill_latency();
        wait_frame();
        tick();

        // T3: destination held off for 50 cycles after fill.
        dst_ready = 0;
        do_fill(0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            chk("t3_busy", {63'd0, busy}, 64'd1);
            chk("t3_no_start", {63'd0, start_out}, 64'd0);
            tick();
        end
        dst_ready = 1;
        tick();
        chk("t3_start_after_ready", {63'd0, start_out}, 64'd1);
        wait_frame();
        tick();

        // T4: 197th ch2 write during fill, plus a write while waiting.
        chk("t4_overflow_before", {63'd0, overflow_err}, 64'd0);
        dst_ready = 0;
        do_fill(0, 1, 1, 0);
        chk("t4_overflow_fill", {63'd0, overflow_err}, 64'd1);
        in_valid = 6'h3F;
        for (int c = 0; c < NCH; c++) in_pixel[c] = 8'($urandom_range(0, 255));
        tick();
        in_valid = '0;
        tick();
        chk("t4_overflow_wait", {63'd0, overflow_err}, 64'd1);
        dst_ready = 1;
        wait_frame();
        chk("t4_overflow_sticky", {63'd0, overflow_err}, 64'd1);
        tick();

        // T5: reset in the middle of a replay, then a fresh frame.
        do_fill(2, 0, 0, 1);
        n = 0;
        while (!(out_valid != 6'd0 && run_len >= 100) && n < 1000) begin
            tick();
            n++;
        end
        chk("t5_reach_pix100", 64'(n < 1000), 64'd1);
        rst_n = 0;
        tick();
        sb.delete();
        chk("t5_out_valid", {58'd0, out_valid}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_overflow_clr", {63'd0, overflow_err}, 64'd0);
        rst_n = 1;
        tick();
        do_fill(0, 0, 0, 1);
        wait_frame();
        tick();

        // T6: two back-to-back frames with new data each time.
        do_fill(1, 0, 0, 0);
        check_fill_latency();
        wait_frame();
        tick();
        do_fill(2, 1, 0, 1);
        wait_frame();
        repeat (5) tick();

        chk("frame_done_count", 64'(fd_cnt), 64'(exp_fd));
        chk("start_count", 64'(start_cnt), 64'(exp_start));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_overflow", {63'd0, overflow_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
